// File: rtl/game_state_spi_tx.sv
// Frames one game-screen snapshot as header, one 16-bit word per row and an XOR
// checksum, then shifts it out MSB first on an SPI mode-0 link to the display MCU.
module game_state_spi_tx #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] screen,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 busy,
  output logic                 done
);

  localparam int NBYTES = 2 * ROWS + 2;
  localparam int NBITS  = 8 * NBYTES;
  localparam int BIT_W  = $clog2(NBITS);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [DIV_W-1:0]     div_cnt;
  logic                 phase;
  logic [BIT_W-1:0]     bit_idx;
  logic [BIT_W-1:0]     rev_idx;
  logic [ROWS*COLS-1:0] snap;
  logic [NBITS-1:0]     frame;
  logic [15:0]          row_word;
  logic [7:0]           chk;
  logic                 div_last;
  logic                 bit_last;
  logic                 accept;
  logic                 cs_n_d;
  logic                 sclk_d;
  logic                 mosi_d;
  logic                 busy_d;
  logic                 done_d;

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_idx == BIT_W'(NBITS - 1));
  assign rev_idx  = BIT_W'(NBITS - 1) - bit_idx;

  // Pins lag the state by one cycle, so the IDLE cycles still covered by busy
  // or done must not restart a frame.
  assign accept = (state_q == IDLE) && start && !busy && !done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LEAD;
      LEAD:    if (div_last) state_d = SHIFT;
      SHIFT:   if (div_last && phase && bit_last) state_d = TRAIL;
      TRAIL:   if (div_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_idx <= '0;
      snap    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          div_cnt <= '0;
          phase   <= 1'b0;
          bit_idx <= '0;
          if (accept) snap <= screen;
        end
        SHIFT: begin
          div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
          if (div_last) begin
            phase <= ~phase;
            if (phase && !bit_last) bit_idx <= bit_idx + BIT_W'(1);
          end
        end
        default: begin
          div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
        end
      endcase
    end
  end

  // Whole frame image from the snapshot, first transmitted bit at the top.
  always_comb begin
    frame    = '0;
    chk      = '0;
    row_word = '0;
    frame[NBITS-1 -: 8] = HEADER;
    for (int r = 0; r < ROWS; r++) begin
      row_word = '0;
      row_word[COLS-1:0] = snap[r*COLS +: COLS];
      frame[NBITS-9-16*r -: 16] = row_word;
      chk = chk ^ row_word[15:8] ^ row_word[7:0];
    end
    frame[7:0] = chk;
  end

  always_comb begin
    cs_n_d = (state_q == IDLE);
    sclk_d = (state_q == SHIFT) && phase;
    busy_d = (state_q != IDLE);
    done_d = busy && (state_q == IDLE);
    mosi_d = 1'b0;
    case (state_q)
      LEAD:    mosi_d = frame[NBITS-1];
      SHIFT:   mosi_d = frame[rev_idx];
      default: mosi_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_n <= 1'b1;
      sclk <= 1'b0;
      mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cs_n <= cs_n_d;
      sclk <= sclk_d;
      mosi <= mosi_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_game_state_spi_tx.sv
// Directed bench for game_state_spi_tx: one instance at CLK_DIV=2, one at CLK_DIV=1,
// with a receiver that samples mosi on sclk rising edges.
module tb_game_state_spi_tx;

  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int NBYTES = 42;
  localparam int NBITS  = 336;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           start;
  logic [ROWS*COLS-1:0] screen;
  logic [1:0]           cs_n, sclk, mosi, busy, done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] rx        [0:1][0:NBYTES-1];
  logic [7:0] exp_bytes [0:NBYTES-1];
  int         bit_cnt   [0:1];
  int         busy_cnt  [0:1];
  int         done_cnt  [0:1];
  int         glitch_cnt[0:1];
  logic [1:0] prev_cs_n, prev_sclk, prev_mosi;

  always #5 clk = ~clk;

  game_state_spi_tx #(.ROWS(ROWS), .COLS(COLS), .CLK_DIV(2)) dut_div2 (
    .clk(clk), .reset(reset), .start(start[0]), .screen(screen),
    .cs_n(cs_n[0]), .sclk(sclk[0]), .mosi(mosi[0]), .busy(busy[0]), .done(done[0])
  );

  game_state_spi_tx #(.ROWS(ROWS), .COLS(COLS), .CLK_DIV(1)) dut_div1 (
    .clk(clk), .reset(reset), .start(start[1]), .screen(screen),
    .cs_n(cs_n[1]), .sclk(sclk[1]), .mosi(mosi[1]), .busy(busy[1]), .done(done[1])
  );

  // Receiver: restarts on cs_n falling, captures a bit on every sclk rise.
  initial begin
    for (int i = 0; i < 2; i++) begin
      bit_cnt[i] = 0;
      busy_cnt[i] = 0;
      done_cnt[i] = 0;
      glitch_cnt[i] = 0;
      for (int k = 0; k < NBYTES; k++) rx[i][k] = 8'h00;
    end
    prev_cs_n = 2'b11;
    prev_sclk = 2'b00;
    prev_mosi = 2'b00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (prev_cs_n[i] && !cs_n[i]) begin
          bit_cnt[i] = 0;
          busy_cnt[i] = 0;
          for (int k = 0; k < NBYTES; k++) rx[i][k] = 8'h00;
        end
        if (busy[i]) busy_cnt[i]++;
        if (done[i]) done_cnt[i]++;
        if (mosi[i] != prev_mosi[i] && sclk[i]) glitch_cnt[i]++;
        if (sclk[i] && !prev_sclk[i]) begin
          if (bit_cnt[i] < NBITS) rx[i][bit_cnt[i] / 8][7 - (bit_cnt[i] % 8)] = mosi[i];
          bit_cnt[i]++;
        end
      end
      prev_cs_n = cs_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic [ROWS*COLS-1:0] scr);
    @(negedge clk);
    screen = scr;
    start[inst] = 1'b1;
    @(negedge clk);
    start[inst] = 1'b0;
  endtask

  task automatic waitDone(input int inst, input int budget);
    int n;
    n = 0;
    while (!done[inst] && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("done_seen%0d", inst), 32'(done[inst]), 32'd1);
    @(negedge clk);
  endtask

  task automatic clearExpected();
    for (int k = 0; k < NBYTES; k++) exp_bytes[k] = 8'h00;
    exp_bytes[0] = 8'hA5;
  endtask

  task automatic checkFrame(input int inst, input string name);
    checkOutput($sformatf("%s_bits", name), 32'(bit_cnt[inst]), 32'(NBITS));
    for (int k = 0; k < NBYTES; k++)
      checkOutput($sformatf("%s_byte%0d", name, k), 32'(rx[inst][k]), 32'(exp_bytes[k]));
  endtask

  logic [ROWS*COLS-1:0] scr;
  int d0, g0;

  initial begin
    reset  = 1'b0;
    start  = 2'b00;
    screen = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", 32'(cs_n), 32'h3);
    checkOutput("rst_sclk", 32'(sclk), 32'h0);
    checkOutput("rst_mosi", 32'(mosi), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);

    // start while in reset must be ignored
    start = 2'b11;
    @(negedge clk);
    start = 2'b00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_start_busy", 32'(busy), 32'h0);

    // blank screen at CLK_DIV=2
    clearExpected();
    d0 = done_cnt[0];
    applyStimulus(0, '0);
    checkOutput("busy_edge0", 32'(busy[0]), 32'd0);
    @(negedge clk);
    checkOutput("busy_edge1", 32'(busy[0]), 32'd1);
    checkOutput("cs_n_edge1", 32'(cs_n[0]), 32'd0);
    waitDone(0, 2000);
    checkFrame(0, "blank");
    checkOutput("blank_busy_len", 32'(busy_cnt[0]), 32'd1348);
    checkOutput("blank_done_cnt", 32'(done_cnt[0] - d0), 32'd1);

    // row 0, column 0
    clearExpected();
    exp_bytes[2]  = 8'h01;
    exp_bytes[41] = 8'h01;
    scr = '0;
    scr[0] = 1'b1;
    applyStimulus(0, scr);
    waitDone(0, 2000);
    checkFrame(0, "r0c0");

    // full bottom row: word 0x03FF in bytes 39/40
    clearExpected();
    exp_bytes[39] = 8'h03;
    exp_bytes[40] = 8'hFF;
    exp_bytes[41] = 8'hFC;
    scr = '0;
    scr[199:190] = 10'h3FF;
    applyStimulus(0, scr);
    waitDone(0, 2000);
    checkFrame(0, "row19");

    // snapshot hold and dropped second start
    clearExpected();
    exp_bytes[1]  = 8'h02;
    exp_bytes[12] = 8'h08;
    exp_bytes[41] = 8'h0A;
    scr = '0;
    scr[9]  = 1'b1;
    scr[53] = 1'b1;
    d0 = done_cnt[0];
    applyStimulus(0, scr);
    repeat (4) @(negedge clk);
    screen = '1;
    repeat (95) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    waitDone(0, 2000);
    checkFrame(0, "snap");
    checkOutput("snap_busy_len", 32'(busy_cnt[0]), 32'd1348);
    repeat (20) @(negedge clk);
    checkOutput("snap_no_requeue", 32'(busy[0]), 32'd0);
    checkOutput("snap_done_cnt", 32'(done_cnt[0] - d0), 32'd1);

    // reset mid-frame, then a clean frame
    scr = '0;
    scr[0] = 1'b1;
    d0 = done_cnt[0];
    applyStimulus(0, scr);
    repeat (299) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_cs_n", 32'(cs_n[0]), 32'd1);
    checkOutput("midrst_sclk", 32'(sclk[0]), 32'd0);
    checkOutput("midrst_mosi", 32'(mosi[0]), 32'd0);
    checkOutput("midrst_busy", 32'(busy[0]), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midrst_no_done", 32'(done_cnt[0] - d0), 32'd0);
    clearExpected();
    exp_bytes[39] = 8'h03;
    exp_bytes[40] = 8'hFF;
    exp_bytes[41] = 8'hFC;
    scr = '0;
    scr[199:190] = 10'h3FF;
    applyStimulus(0, scr);
    waitDone(0, 2000);
    checkFrame(0, "after_rst");

    // CLK_DIV=1 receiver check with alternating columns
    clearExpected();
    exp_bytes[1]  = 8'h01;
    exp_bytes[2]  = 8'h55;
    exp_bytes[21] = 8'h02;
    exp_bytes[22] = 8'hAA;
    exp_bytes[41] = 8'hFC;
    scr = '0;
    scr[9:0]     = 10'h155;
    scr[109:100] = 10'h2AA;
    g0 = glitch_cnt[1];
    d0 = done_cnt[1];
    applyStimulus(1, scr);
    waitDone(1, 1000);
    checkFrame(1, "div1");
    checkOutput("div1_busy_len", 32'(busy_cnt[1]), 32'd674);
    checkOutput("div1_done_cnt", 32'(done_cnt[1] - d0), 32'd1);
    checkOutput("div1_mosi_stable", 32'(glitch_cnt[1] - g0), 32'd0);
    checkOutput("div2_mosi_stable", 32'(glitch_cnt[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
